mcu_mem_arbiter: RTL and testbench
==================================

# mcu_mem_arbiter

Sequencer and arbiter for the shared cartridge memory bus (ROM/SRAM), placed between the SNES bus front end, the MCU command block (which issues `mcu_rrq`/`mcu_wrq` and consumes `mcu_rq_rdy`) and the external memory pins. SNES accesses always take priority. MCU read and write requests are latched and served in free bus slots. Every access is sequenced as a fixed-length strobe on the memory control lines.

## Interface
- `ACCESS_CYCLES`, default 4: clock cycles per memory access; legal range 2..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `snes_rd_start`  in  1  one-cycle pulse: SNES read begins; `snes_addr` is valid.
- `snes_wr_start`  in  1  one-cycle pulse: SNES write begins; `snes_addr` and `snes_wdata` are valid.
- `snes_addr`  in  24  SNES-side memory address (already mapped and masked).
- `snes_wdata`  in  8  SNES write data.
- `snes_rdata`  out  8  registered SNES read data.
- `snes_rd_valid`  out  1  one-cycle pulse: `snes_rdata` has been updated.
- `mcu_rrq`  in  1  one-cycle pulse: MCU read request.
- `mcu_wrq`  in  1  one-cycle pulse: MCU write request.
- `mcu_addr`  in  24  MCU address, sampled on the request cycle.
- `mcu_wdata`  in  8  MCU write data, sampled on the request cycle.
- `mcu_rdata`  out  8  registered MCU read data.
- `mcu_rq_rdy`  out  1  level; 1 = MCU channel idle / last request complete.
- `mem_addr`  out  24  memory address.
- `mem_wdata`  out  8  memory write data.
- `mem_rdata`  in  8  memory read data.
- `mem_oe_n`  out  1  output enable, active-low.
- `mem_we_n`  out  1  write enable, active-low.
- `mem_data_oe`  out  1  1 = FPGA drives the memory data bus.

## Operation
- States: IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR. A 4-bit counter `cnt` runs in every non-IDLE state.
- MCU request latch: a pulse on `mcu_rrq`/`mcu_wrq` while `mcu_rq_rdy`=1 does three things:
  - captures `mcu_addr`/`mcu_wdata` and the kind (read/write);
  - sets `mcu_pend`;
  - drives `mcu_rq_rdy`=0 on the next edge.
- A request arriving while `mcu_rq_rdy`=0 is ignored. If `mcu_rrq` and `mcu_wrq` arrive in the same cycle, the read wins.
- SNES latch: a start pulse received outside IDLE sets `snes_pend` and captures addr/data/kind. A second SNES start while `snes_pend`=1 overwrites the latch (last start wins).
- Arbitration in IDLE, evaluated in this order each edge:
  1. live SNES start;
  2. `snes_pend`;
  3. `mcu_pend`;
  4. stay IDLE.
  Granting clears the corresponding pend flag.
- Read state, entered at edge E:
  - `mem_addr` loaded, `mem_oe_n`=0, `mem_data_oe`=0, `cnt`=1.
  - At edge E+ACCESS_CYCLES: `mem_rdata` is captured into `snes_rdata` (pulse `snes_rd_valid`) or into `mcu_rdata`; `mem_oe_n`=1; back to IDLE.
- Write state, entered at edge E:
  - `mem_addr`/`mem_wdata` loaded, `mem_data_oe`=1, `mem_we_n`=0.
  - At edge E+ACCESS_CYCLES-1: `mem_we_n`=1 (data hold cycle).
  - At edge E+ACCESS_CYCLES: `mem_data_oe`=0; back to IDLE.
- MCU completion: `mcu_rq_rdy` returns to 1 on the same edge the MCU state returns to IDLE, with `mcu_rdata` already valid. `mcu_rq_rdy` is always low for at least 2 cycles, so the consumer's rising-edge detector fires exactly once per request.
- `mem_addr` and `mem_wdata` hold their last value in IDLE.
- `mem_oe_n` and `mem_we_n` are never both 0.

## Timing
- Reset values (asynchronous, also mid-access):
  - state IDLE; `cnt`=0; `snes_pend`=`mcu_pend`=0;
  - `mem_oe_n`=1, `mem_we_n`=1, `mem_data_oe`=0;
  - `mem_addr`=0, `mem_wdata`=0;
  - `snes_rdata`=0, `snes_rd_valid`=0, `mcu_rdata`=0, `mcu_rq_rdy`=1.
  - An aborted MCU request is dropped; no completion is signalled.
- Minimum slot: ACCESS_CYCLES+1 cycles per access, because one IDLE cycle always separates accesses (bus turnaround).
- SNES read latency, start pulse to `snes_rd_valid`:
  - bus idle: ACCESS_CYCLES cycles;
  - MCU access in flight: adds up to ACCESS_CYCLES+1 cycles.
- MCU latency, request to `mcu_rq_rdy` rising: ACCESS_CYCLES+2 cycles with no SNES traffic. SNES traffic may add a full SNES slot.
- Simultaneous SNES start and MCU request in IDLE: SNES is granted, the MCU request is latched, and MCU is served in the next IDLE slot.
- `cnt` never wraps, because ACCESS_CYCLES ≤ 15.

## Test plan
- Reset, then `mcu_rrq` with `mcu_addr`=0x123456 and `mem_rdata`=0xA5 (ACCESS_CYCLES=4) → `mem_addr`=0x123456, `mem_oe_n` low 4 cycles, `mcu_rdata`=0xA5, `mcu_rq_rdy` 1→0→1 with 0 lasting 5 cycles.
- `mcu_wrq` with addr 0x000010, data 0x3C → `mem_we_n` low 3 cycles, `mem_data_oe` high 4 cycles, `mem_wdata`=0x3C throughout, `mem_oe_n` stays 1.
- `snes_rd_start` and `mcu_rrq` in the same cycle → SNES read completes first (`snes_rd_valid` after 4 cycles), MCU read starts after one IDLE cycle, and `mcu_rq_rdy` rises 10 cycles after the request.
- `snes_wr_start` during an MCU read → SNES is latched and its write begins exactly one IDLE cycle after the MCU read ends; a second `mcu_rrq` while `mcu_rq_rdy`=0 produces no extra access.
- `rst_n` asserted mid-write → `mem_we_n`=1, `mem_data_oe`=0 and `mcu_rq_rdy`=1 immediately (asynchronously); after release the block is IDLE and no stale access occurs.

Source files
------------

// File: rtl/mcu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// mcu_mem_arbiter : shared cartridge-bus sequencer, SNES priority over MCU
// Revision 1.0
// ============================================================================
module mcu_mem_arbiter #(
    parameter int ACCESS_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snes_rd_start,
    input  logic        snes_wr_start,
    input  logic [23:0] snes_addr,
    input  logic [7:0]  snes_wdata,
    output logic [7:0]  snes_rdata,
    output logic        snes_rd_valid,
    input  logic        mcu_rrq,
    input  logic        mcu_wrq,
    input  logic [23:0] mcu_addr,
    input  logic [7:0]  mcu_wdata,
    output logic [7:0]  mcu_rdata,
    output logic        mcu_rq_rdy,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        mem_data_oe
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SNES_RD = 3'd1,
        SNES_WR = 3'd2,
        MCU_RD  = 3'd3,
        MCU_WR  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES);
    localparam logic [3:0] HOLD_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;

    logic        snes_pend;
    logic        snes_pend_wr;
    logic [23:0] snes_pend_addr;
    logic [7:0]  snes_pend_wdata;

    logic        mcu_pend;
    logic        mcu_is_wr;
    logic [23:0] mcu_lat_addr;
    logic [7:0]  mcu_lat_wdata;

    logic        snes_start;
    logic        mcu_accept;

    logic        grant;
    logic        grant_snes;
    logic        grant_wr;
    logic [23:0] grant_addr;
    logic [7:0]  grant_wdata;

    assign snes_start = snes_rd_start | snes_wr_start;
    assign mcu_accept = (mcu_rrq | mcu_wrq) & mcu_rq_rdy;

    // Priority: live SNES start, then latched SNES, then latched MCU.
    always_comb begin
        grant       = 1'b1;
        grant_snes  = 1'b1;
        grant_wr    = 1'b0;
        grant_addr  = snes_addr;
        grant_wdata = snes_wdata;
        if (snes_start) begin
            grant_wr = ~snes_rd_start;
        end else if (snes_pend) begin
            grant_wr    = snes_pend_wr;
            grant_addr  = snes_pend_addr;
            grant_wdata = snes_pend_wdata;
        end else if (mcu_pend) begin
            grant_snes  = 1'b0;
            grant_wr    = mcu_is_wr;
            grant_addr  = mcu_lat_addr;
            grant_wdata = mcu_lat_wdata;
        end else begin
            grant = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            snes_pend       <= 1'b0;
            snes_pend_wr    <= 1'b0;
            snes_pend_addr  <= 24'd0;
            snes_pend_wdata <= 8'd0;
            mcu_pend        <= 1'b0;
            mcu_is_wr       <= 1'b0;
            mcu_lat_addr    <= 24'd0;
            mcu_lat_wdata   <= 8'd0;
            mem_addr        <= 24'd0;
            mem_wdata       <= 8'd0;
            mem_oe_n        <= 1'b1;
            mem_we_n        <= 1'b1;
            mem_data_oe     <= 1'b0;
            snes_rdata      <= 8'd0;
            snes_rd_valid   <= 1'b0;
            mcu_rdata       <= 8'd0;
            mcu_rq_rdy      <= 1'b1;
        end else begin
            snes_rd_valid <= 1'b0;

            if (mcu_accept) begin
                mcu_pend      <= 1'b1;
                mcu_is_wr     <= ~mcu_rrq;
                mcu_lat_addr  <= mcu_addr;
                mcu_lat_wdata <= mcu_wdata;
                mcu_rq_rdy    <= 1'b0;
            end

            if (state != IDLE && snes_start) begin
                snes_pend       <= 1'b1;
                snes_pend_wr    <= ~snes_rd_start;
                snes_pend_addr  <= snes_addr;
                snes_pend_wdata <= snes_wdata;
            end

            case (state)
                IDLE: begin
                    if (grant) begin
                        cnt      <= 4'd1;
                        mem_addr <= grant_addr;
                        if (grant_snes) begin
                            snes_pend <= 1'b0;
                        end else begin
                            mcu_pend <= 1'b0;
                        end
                        if (grant_wr) begin
                            state       <= grant_snes ? SNES_WR : MCU_WR;
                            mem_wdata   <= grant_wdata;
                            mem_we_n    <= 1'b0;
                            mem_data_oe <= 1'b1;
                        end else begin
                            state    <= grant_snes ? SNES_RD : MCU_RD;
                            mem_oe_n <= 1'b0;
                        end
                    end
                end
                default: begin
                    cnt <= cnt + 4'd1;
                    // Release WE one cycle early so data is held past the strobe.
                    if (cnt == HOLD_CNT && (state == SNES_WR || state == MCU_WR)) begin
                        mem_we_n <= 1'b1;
                    end
                    if (cnt == LAST_CNT) begin
                        state       <= IDLE;
                        cnt         <= 4'd0;
                        mem_oe_n    <= 1'b1;
                        mem_we_n    <= 1'b1;
                        mem_data_oe <= 1'b0;
                        if (state == SNES_RD) begin
                            snes_rdata    <= mem_rdata;
                            snes_rd_valid <= 1'b1;
                        end
                        if (state == MCU_RD) begin
                            mcu_rdata <= mem_rdata;
                        end
                        if (state == MCU_RD || state == MCU_WR) begin
                            mcu_rq_rdy <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mcu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mcu_mem_arbiter : directed table-driven bench for mcu_mem_arbiter
// Revision 1.0
// ============================================================================
module tb_mcu_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        snes_rd_start;
    logic        snes_wr_start;
    logic [23:0] snes_addr;
    logic [7:0]  snes_wdata;
    logic [7:0]  snes_rdata;
    logic        snes_rd_valid;
    logic        mcu_rrq;
    logic        mcu_wrq;
    logic [23:0] mcu_addr;
    logic [7:0]  mcu_wdata;
    logic [7:0]  mcu_rdata;
    logic        mcu_rq_rdy;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic        mem_data_oe;

    mcu_mem_arbiter #(.ACCESS_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .snes_rd_start(snes_rd_start),
        .snes_wr_start(snes_wr_start),
        .snes_addr    (snes_addr),
        .snes_wdata   (snes_wdata),
        .snes_rdata   (snes_rdata),
        .snes_rd_valid(snes_rd_valid),
        .mcu_rrq      (mcu_rrq),
        .mcu_wrq      (mcu_wrq),
        .mcu_addr     (mcu_addr),
        .mcu_wdata    (mcu_wdata),
        .mcu_rdata    (mcu_rdata),
        .mcu_rq_rdy   (mcu_rq_rdy),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_oe_n     (mem_oe_n),
        .mem_we_n     (mem_we_n),
        .mem_data_oe  (mem_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 MCU read, 1 MCU write, 2 SNES read, 3 SNES write
    typedef struct {
        logic [1:0]  kind;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          oe_cyc;
        int          we_cyc;
        int          doe_cyc;
        int          rdy_low;
        int          valid_at;
        logic [7:0]  exp_mcu;
        logic [7:0]  exp_snes;
    } vec_t;

    localparam int NS = 16;

    vec_t        vecs[6];
    logic        oe_s[NS];
    logic        we_s[NS];
    logic        doe_s[NS];
    logic        rdy_s[NS];
    logic        val_s[NS];
    logic [23:0] addr_s[NS];
    logic [7:0]  wd_s[NS];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge, drop all pulses, then sample outputs at index i.
    task automatic step_sample(input int i);
        @(posedge clk);
        #1;
        snes_rd_start = 1'b0;
        snes_wr_start = 1'b0;
        mcu_rrq       = 1'b0;
        mcu_wrq       = 1'b0;
        oe_s[i]  = mem_oe_n;
        we_s[i]  = mem_we_n;
        doe_s[i] = mem_data_oe;
        rdy_s[i] = mcu_rq_rdy;
        val_s[i] = snes_rd_valid;
        addr_s[i] = mem_addr;
        wd_s[i]  = mem_wdata;
    endtask

    function automatic int rdy_rise(input int n);
        for (int k = 1; k < n; k++)
            if (!rdy_s[k-1] && rdy_s[k]) return k;
        return -1;
    endfunction

    initial begin
        int oe_c, we_c, doe_c, rdy_c, val_c, val_first, bad_addr, bad_wd, both;

        vecs[0] = '{2'd0, 24'h123456, 8'h00, 8'hA5, 4, 0, 0, 5, -1, 8'hA5, 8'h00};
        vecs[1] = '{2'd1, 24'h000010, 8'h3C, 8'h00, 0, 3, 4, 5, -1, 8'hA5, 8'h00};
        vecs[2] = '{2'd2, 24'hABCDEF, 8'h00, 8'h5A, 4, 0, 0, 0,  4, 8'hA5, 8'h5A};
        vecs[3] = '{2'd3, 24'h00FFFF, 8'hC3, 8'h00, 0, 3, 4, 0, -1, 8'hA5, 8'h5A};
        vecs[4] = '{2'd0, 24'hFFFFFF, 8'h00, 8'h00, 4, 0, 0, 5, -1, 8'h00, 8'h5A};
        vecs[5] = '{2'd2, 24'h000000, 8'h00, 8'hFF, 4, 0, 0, 0,  4, 8'h00, 8'hFF};

        rst_n = 1'b0;
        snes_rd_start = 1'b0; snes_wr_start = 1'b0;
        snes_addr = 24'd0; snes_wdata = 8'd0;
        mcu_rrq = 1'b0; mcu_wrq = 1'b0;
        mcu_addr = 24'd0; mcu_wdata = 8'd0;
        mem_rdata = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_oe_n",   32'(mem_oe_n), 32'd1);
        check("rst_we_n",   32'(mem_we_n), 32'd1);
        check("rst_doe",    32'(mem_data_oe), 32'd0);
        check("rst_addr",   32'(mem_addr), 32'd0);
        check("rst_wdata",  32'(mem_wdata), 32'd0);
        check("rst_srdata", 32'(snes_rdata), 32'd0);
        check("rst_valid",  32'(snes_rd_valid), 32'd0);
        check("rst_mrdata", 32'(mcu_rdata), 32'd0);
        check("rst_rdy",    32'(mcu_rq_rdy), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Isolated single accesses on an otherwise quiet bus.
        for (int v = 0; v < 6; v++) begin
            mem_rdata = vecs[v].rdata;
            for (int i = 0; i < 12; i++) begin
                if (i == 0) begin
                    case (vecs[v].kind)
                        2'd0: begin mcu_rrq = 1'b1; mcu_addr = vecs[v].addr; end
                        2'd1: begin mcu_wrq = 1'b1; mcu_addr = vecs[v].addr; mcu_wdata = vecs[v].wdata; end
                        2'd2: begin snes_rd_start = 1'b1; snes_addr = vecs[v].addr; end
                        default: begin snes_wr_start = 1'b1; snes_addr = vecs[v].addr; snes_wdata = vecs[v].wdata; end
                    endcase
                end
                step_sample(i);
            end
            oe_c = 0; we_c = 0; doe_c = 0; rdy_c = 0; val_c = 0; val_first = -1;
            bad_addr = 0; bad_wd = 0; both = 0;
            for (int i = 0; i < 12; i++) begin
                if (!oe_s[i]) oe_c++;
                if (!we_s[i]) we_c++;
                if (doe_s[i]) doe_c++;
                if (!rdy_s[i]) rdy_c++;
                if (val_s[i]) begin val_c++; if (val_first < 0) val_first = i; end
                if ((!oe_s[i] || !we_s[i] || doe_s[i]) && addr_s[i] != vecs[v].addr) bad_addr++;
                if (doe_s[i] && wd_s[i] != vecs[v].wdata) bad_wd++;
                if (!oe_s[i] && !we_s[i]) both++;
            end
            check($sformatf("v%0d_oe_cycles", v),  32'(oe_c),  32'(vecs[v].oe_cyc));
            check($sformatf("v%0d_we_cycles", v),  32'(we_c),  32'(vecs[v].we_cyc));
            check($sformatf("v%0d_doe_cycles", v), 32'(doe_c), 32'(vecs[v].doe_cyc));
            check($sformatf("v%0d_rdy_low", v),    32'(rdy_c), 32'(vecs[v].rdy_low));
            check($sformatf("v%0d_valid_cnt", v),  32'(val_c), (vecs[v].valid_at >= 0) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_valid_at", v),   32'(val_first), 32'(vecs[v].valid_at));
            check($sformatf("v%0d_addr_bad", v),   32'(bad_addr), 32'd0);
            check($sformatf("v%0d_wdata_bad", v),  32'(bad_wd), 32'd0);
            check($sformatf("v%0d_oe_we_both", v), 32'(both), 32'd0);
            check($sformatf("v%0d_mcu_rdata", v),  32'(mcu_rdata), 32'(vecs[v].exp_mcu));
            check($sformatf("v%0d_snes_rdata", v), 32'(snes_rdata), 32'(vecs[v].exp_snes));
        end

        // Simultaneous SNES read and MCU read: SNES first, one IDLE gap, then MCU.
        mem_rdata = 8'h77;
        for (int i = 0; i < NS; i++) begin
            if (i == 0) begin
                snes_rd_start = 1'b1; snes_addr = 24'h0A0B0C;
                mcu_rrq = 1'b1; mcu_addr = 24'h0D0E0F;
            end
            step_sample(i);
        end
        val_first = -1;
        for (int i = 0; i < NS; i++) if (val_s[i] && val_first < 0) val_first = i;
        check("sim_snes_valid_at", 32'(val_first), 32'd4);
        check("sim_addr_snes",     32'(addr_s[0]), 32'h0A0B0C);
        check("sim_gap_oe_n",      32'(oe_s[4]), 32'd1);
        check("sim_mcu_oe_n",      32'(oe_s[5]), 32'd0);
        check("sim_addr_mcu",      32'(addr_s[5]), 32'h0D0E0F);
        check("sim_rdy_rise",      32'(rdy_rise(NS)), 32'd9);
        check("sim_mcu_rdata",     32'(mcu_rdata), 32'h77);
        check("sim_snes_rdata",    32'(snes_rdata), 32'h77);

        // SNES write arrives mid MCU read; a second MCU read while busy is ignored.
        mem_rdata = 8'h11;
        for (int i = 0; i < NS; i++) begin
            if (i == 0) begin mcu_rrq = 1'b1; mcu_addr = 24'h222222; end
            if (i == 2) begin snes_wr_start = 1'b1; snes_addr = 24'h333333; snes_wdata = 8'h96; end
            if (i == 3) begin mcu_rrq = 1'b1; mcu_addr = 24'h444444; end
            step_sample(i);
        end
        oe_c = 0;
        for (int i = 0; i < NS; i++) if (!oe_s[i]) oe_c++;
        we_c = 0;
        for (int i = 0; i < NS; i++) if (!we_s[i]) we_c++;
        check("lat_rdy_rise",   32'(rdy_rise(NS)), 32'd5);
        check("lat_we_gap",     32'(we_s[5]), 32'd1);
        check("lat_we_start",   32'(we_s[6]), 32'd0);
        check("lat_wr_addr",    32'(addr_s[6]), 32'h333333);
        check("lat_wr_data",    32'(wd_s[6]), 32'h96);
        check("lat_doe_end",    32'(doe_s[10]), 32'd0);
        check("lat_oe_total",   32'(oe_c), 32'd4);
        check("lat_we_total",   32'(we_c), 32'd3);
        check("lat_rdy_final",  32'(rdy_s[NS-1]), 32'd1);
        check("lat_mcu_rdata",  32'(mcu_rdata), 32'h11);

        // Asynchronous reset in the middle of an MCU write.
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin mcu_wrq = 1'b1; mcu_addr = 24'h555555; mcu_wdata = 8'hEE; end
            step_sample(i);
        end
        check("ar_pre_we_n", 32'(mem_we_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_we_n", 32'(mem_we_n), 32'd1);
        check("ar_doe",  32'(mem_data_oe), 32'd0);
        check("ar_rdy",  32'(mcu_rq_rdy), 32'd1);
        check("ar_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step_sample(i);
        oe_c = 0; we_c = 0; doe_c = 0; rdy_c = 0;
        for (int i = 0; i < 10; i++) begin
            if (!oe_s[i]) oe_c++;
            if (!we_s[i]) we_c++;
            if (doe_s[i]) doe_c++;
            if (!rdy_s[i]) rdy_c++;
        end
        check("ar_post_oe", 32'(oe_c), 32'd0);
        check("ar_post_we", 32'(we_c), 32'd0);
        check("ar_post_doe", 32'(doe_c), 32'd0);
        check("ar_post_rdy_low", 32'(rdy_c), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
